// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings,
// a constant-foldable clog2 and the widest legal stage payload layout.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int MAX_W  = 64;
  localparam int MAX_SW = 6;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Payload carried between register slices, sized for the widest shifter.
  // The top keeps a W-sized copy of the same field layout so no dead bits
  // are registered in narrower builds.
  typedef struct packed {
    logic [MAX_W-1:0]  data;
    logic [1:0]        ctrl;
    logic [MAX_SW-1:0] shamt;
    logic              carry;
  } stage_payload_t;

endpackage

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: shifts or rotates by the
// fixed amount AMT when enabled and updates the running shifter carry.
module shift_level
  import shifter_pkg::*;
#(
  parameter int W   = 32,
  parameter int AMT = 1
) (
  input  logic [W-1:0] data_i,
  input  logic [1:0]   ctrl_i,
  input  logic         en_i,
  input  logic         carry_i,
  output logic [W-1:0] data_o,
  output logic         carry_o
);

  logic [W-1:0] shifted;
  logic         shout;

  // Shift by AMT and pick the last bit that falls off the end.
  always_comb begin
    shifted = data_i;
    shout   = carry_i;
    case (ctrl_i)
      SH_LSL: begin
        shifted = data_i << AMT;
        shout   = data_i[W-AMT];
      end
      SH_LSR: begin
        shifted = data_i >> AMT;
        shout   = data_i[AMT-1];
      end
      SH_ASR: begin
        shifted = $signed(data_i) >>> AMT;
        shout   = data_i[AMT-1];
      end
      default: begin
        // Rotate: the bit landing in the MSB is the one that wrapped around.
        shifted = (data_i >> AMT) | (data_i << (W - AMT));
        shout   = data_i[AMT-1];
      end
    endcase
  end

  // A disabled level is a straight pass-through for both data and carry.
  always_comb begin
    data_o  = en_i ? shifted : data_i;
    carry_o = en_i ? shout : carry_i;
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready flow control. The SW shift levels
// are split into STAGES groups of L levels, LSB-first, with a register slice
// after each group. Each slice holds valid, data, op, shift amount and the
// running carry; empty slices accept data even while downstream is stalled.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int W      = 32,
  parameter int STAGES = 2,
  localparam int SW    = clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    ctrl,
  input  logic          carry_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          carry_out
);

  // Levels per stage; trailing stages may end up with no levels and act
  // as plain register slices.
  localparam int L = (SW + STAGES - 1) / STAGES;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [1:0]    ctrl;
    logic [SW-1:0] shamt;
    logic          carry;
  } payload_t;

  logic [STAGES-1:0] valid_q;
  payload_t          stage_q [STAGES];
  payload_t          stage_d [STAGES];
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * L;
    localparam int HI  = ((k + 1) * L < SW) ? (k + 1) * L : SW;
    localparam int NLV = (HI > LO) ? (HI - LO) : 0;

    payload_t     src;
    logic [W-1:0] dch [NLV+1];
    logic         cch [NLV+1];

    if (k == 0) begin : g_src_in
      assign src.data  = in_data;
      assign src.ctrl  = ctrl;
      assign src.shamt = shamt;
      assign src.carry = carry_in;
      assign src_valid[k] = in_valid;
    end else begin : g_src_reg
      assign src = stage_q[k-1];
      assign src_valid[k] = valid_q[k-1];
    end

    // Slice k can take a new entry unless it and every slice after it are
    // occupied and the consumer is not taking the head.
    assign ready[k] = out_ready | ~(&valid_q[STAGES-1:k]);

    assign dch[0] = src.data;
    assign cch[0] = src.carry;

    for (genvar j = 0; j < NLV; j++) begin : g_lvl
      shift_level #(
        .W   (W),
        .AMT (1 << (LO + j))
      ) u_level (
        .data_i  (dch[j]),
        .ctrl_i  (src.ctrl),
        .en_i    (src.shamt[LO+j]),
        .carry_i (cch[j]),
        .data_o  (dch[j+1]),
        .carry_o (cch[j+1])
      );
    end

    assign stage_d[k].data  = dch[NLV];
    assign stage_d[k].ctrl  = src.ctrl;
    assign stage_d[k].shamt = src.shamt;
    assign stage_d[k].carry = cch[NLV];
  end

  // Advance each slice when it has room; payload only loads with a valid
  // entry so a held or drained slice keeps its contents stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            stage_q[k] <= stage_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = stage_q[STAGES-1].data;
  assign carry_out = stage_q[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

  localparam int W      = 32;
  localparam int STAGES = 2;
  localparam int SW     = 5;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] shamt = '0;
  logic [1:0]    ctrl = 2'b00;
  logic          carry_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          carry_out;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
  } exp_t;

  exp_t expq[$];
  int   fire_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls = 0;

  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_data;
  logic         hold_carry;

  pipelined_shifter #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shamt     (shamt),
    .ctrl      (ctrl),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: whole-amount shift straight from the operation definitions.
  function automatic exp_t ref_shift(input logic [W-1:0] d, input logic [1:0] c,
                                     input int s, input logic ci);
    exp_t r;
    r.carry = ci;
    r.data  = d;
    case (c)
      LSL: begin
        r.data = d << s;
        if (s != 0) r.carry = d[W-s];
      end
      LSR: begin
        r.data = d >> s;
        if (s != 0) r.carry = d[s-1];
      end
      ASR: begin
        r.data = $signed(d) >>> s;
        if (s != 0) r.carry = d[s-1];
      end
      default: begin
        for (int i = 0; i < W; i++) r.data[i] = d[(i + s) % W];
        if (s != 0) r.carry = r.data[W-1];
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on every consumed result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got 0x%0h with nothing outstanding", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.data || carry_out !== e.carry) begin
            errors++;
            $display("FAIL scoreboard: got data 0x%0h carry %0b expected data 0x%0h carry %0b",
                     out_data, carry_out, e.data, e.carry);
          end
          fire_log.push_back(cyc);
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_valid) begin
          checks++;
          if (out_data !== hold_data || carry_out !== hold_carry) begin
            errors++;
            $display("FAIL stall_stability: got 0x%0h/%0b expected 0x%0h/%0b",
                     out_data, carry_out, hold_data, hold_carry);
          end
        end
        hold_valid = 1'b1;
        hold_data  = out_data;
        hold_carry = carry_out;
      end else begin
        hold_valid = 1'b0;
      end
      if (in_valid && in_ready) expq.push_back(ref_shift(in_data, ctrl, int'(shamt), carry_in));
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] c, input logic [SW-1:0] s,
                      input logic ci, output int t_acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    ctrl     = c;
    shamt    = s;
    carry_in = ci;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
    t_acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int t_acc, input logic [W-1:0] ed,
                            input logic ec);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_data"}, {32'd0, out_data}, {32'd0, ed});
    chk({nm, "_carry"}, {63'd0, carry_out}, {63'd0, ec});
    chk({nm, "_latency"}, 64'(cyc - t_acc), 64'(STAGES));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]  b_d [8] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h80000001, 32'h12345678,
                             32'hF0F0F0F0, 32'h7FFFFFFF, 32'hCAFEBABE, 32'h00010000};
  logic [1:0]    b_c [8] = '{LSL, LSR, ASR, ROR, LSL, ASR, ROR, LSR};
  logic [SW-1:0] b_s [8] = '{5'd1, 5'd2, 5'd8, 5'd16, 5'd13, 5'd17, 5'd31, 5'd0};
  logic          b_ci[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int   t;
    int   n0;
    int   bad;

    m = ref_shift(32'h00000003, LSL, 31, 1'b0);
    chk("model_lsl31", {31'd0, m.carry, m.data}, {31'd0, 1'b1, 32'h80000000});
    m = ref_shift(32'h80000018, ASR, 4, 1'b0);
    chk("model_asr4", {31'd0, m.carry, m.data}, {31'd0, 1'b1, 32'hF8000001});
    m = ref_shift(32'h000000F8, ROR, 4, 1'b0);
    chk("model_ror4", {31'd0, m.carry, m.data}, {31'd0, 1'b1, 32'h8000000F});

    #3;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {32'd0, out_data}, 64'd0);
    chk("reset_carry_out", {63'd0, carry_out}, 64'd0);
    #9 rst_n = 1'b1;
    #1 chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    send(32'h00000003, LSL, 5'd31, 1'b0, t); expect_out("lsl31", t, 32'h80000000, 1'b1);
    send(32'h80000018, ASR, 5'd4, 1'b0, t);  expect_out("asr4", t, 32'hF8000001, 1'b1);
    send(32'h80000018, LSR, 5'd4, 1'b0, t);  expect_out("lsr4", t, 32'h08000001, 1'b1);
    send(32'h000000F8, ROR, 5'd4, 1'b0, t);  expect_out("ror4", t, 32'h8000000F, 1'b1);
    send(32'h000000F8, ROR, 5'd0, 1'b0, t);  expect_out("ror0", t, 32'h000000F8, 1'b0);
    send(32'h000000A5, LSL, 5'd0, 1'b1, t);  expect_out("lsl0_cin", t, 32'h000000A5, 1'b1);
    send(32'h80000000, ASR, 5'd31, 1'b1, t); expect_out("asr31", t, 32'hFFFFFFFF, 1'b0);
    send(32'h00000001, LSR, 5'd1, 1'b0, t);  expect_out("lsr1", t, 32'h00000000, 1'b1);

    stalls = 0;
    n0 = fire_log.size();
    for (int i = 0; i < 8; i++) send(b_d[i], b_c[i], b_s[i], b_ci[i], t);
    drain("burst");
    chk("burst_no_stall", 64'(stalls), 64'd0);
    chk("burst_count", 64'(fire_log.size() - n0), 64'd8);
    bad = 0;
    for (int i = n0 + 1; i < fire_log.size(); i++)
      if (fire_log[i] - fire_log[i-1] != 1) bad++;
    chk("burst_consecutive", 64'(bad), 64'd0);

    out_ready = 1'b0;
    n0 = fire_log.size();
    send(32'h11110000, ROR, 5'd8, 1'b0, t);
    send(32'h00000F0F, LSL, 5'd4, 1'b1, t);
    in_valid = 1'b1;
    in_data  = 32'h80000000;
    ctrl     = ASR;
    shamt    = 5'd3;
    carry_in = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_held_data", {32'd0, out_data}, {32'd0, 32'h00111100});
    chk("bp_held_carry", {63'd0, carry_out}, 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 chk("bp_in_ready_same_cycle", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("bp");
    chk("bp_emitted", 64'(fire_log.size() - n0), 64'd3);

    send(32'h0000FFFF, LSR, 5'd4, 1'b0, t);
    send(32'h12345678, ROR, 5'd12, 1'b1, t);
    chk("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    expq.delete();
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_out_data", {32'd0, out_data}, 64'd0);
    chk("midreset_carry_out", {63'd0, carry_out}, 64'd0);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("no_stale_after_reset", 64'(bad), 64'd0);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    send(32'h000000FF, LSR, 5'd4, 1'b0, t); expect_out("post_reset", t, 32'h0000000F, 1'b1);

    drain("final");
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Pipelined, parametrised barrel shifter for the ALU/execute path. Supports logical left, logical right, arithmetic right and rotate right, and produces an ARM-style shifter carry-out.
- Generalises the single-cycle combinational shifter in three ways: configurable width, configurable pipeline depth, and valid/ready flow control with backpressure.
- Accepts one operation per cycle and returns results in order.

Parameters:
- W, 32: data width; power of two, 2..64.
- STAGES, 2: number of pipeline register stages; 1..SW, where SW = clog2(W).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  W  operand.
- shamt  in  SW  shift amount, 0..W-1.
- ctrl  in  2  operation select: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- carry_in  in  1  carry flag, passed through when shamt==0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  shifted result.
- carry_out  out  1  shifter carry.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All stage valid bits clear, so out_valid=0.
  - out_data=0, carry_out=0; all stage data/ctrl/shamt registers clear.
  - in_ready=1 as soon as rst_n is high.
  - Reset mid-operation discards every in-flight operation; nothing is emitted after release.
- Shift levels: SW levels, level j shifts by 2^j when shamt[j]=1.
  - Levels are applied LSB-first.
  - Stage k (0-based) implements levels k*L .. min((k+1)*L, SW)-1, where L = ceil(SW/STAGES).
- Per-stage registers: valid, data, ctrl, remaining shamt bits, running carry.
- Carry rules:
  - Running carry starts as carry_in.
  - Each active level sets carry to the last bit shifted out: LSL data[W-2^j]; LSR/ASR data[2^j-1]; ROR the new data[W-1].
  - Inactive levels leave carry unchanged.
  - Net effect: shamt==0 gives carry_out=carry_in; otherwise LSL gives in_data[W-shamt], LSR/ASR give in_data[shamt-1], ROR gives result[W-1].
- Operation results:
  - ASR replicates in_data[W-1] into vacated bits.
  - LSL/LSR fill with 0.
  - ROR: result[i] = in_data[(i+shamt) mod W].
- Latency: exactly STAGES cycles from input accept to out_valid, when out_ready is held high.
- Handshake:
  - Input accepted on in_valid & in_ready.
  - Output consumed on out_valid & out_ready.
  - Stage k advances when its successor is empty or advancing; the last stage's successor is advancing iff out_ready.
  - in_ready = !valid[0] | advance[0]. This is combinational from out_ready through the stage valids; no other combinational input-to-output path.
  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
- Throughput: 1 op/cycle with out_ready=1. With out_ready=0 the pipe holds at most STAGES ops, then in_ready=0.
- Stability: while out_valid=1 and out_ready=0, out_data and carry_out remain stable.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 both emits and accepts in the same cycle; no loss or duplication.
- Ordering: strictly in order.
- Out-of-range inputs: shamt is unsigned and always < W. ctrl values are all legal.

Decomposition:
- Shared package shifter_pkg holds:
  - op encodings SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - a clog2 function;
  - stage payload struct {data, ctrl, shamt, carry}.
- One sub-module: shift_level. It is a combinational single-level shifter (parameters W, AMT = 2^j) taking data, ctrl, enable and carry, and producing data and carry.
- The top instantiates SW shift_level instances, with STAGES register slices between the level groups.

Test Plan (W=32, STAGES=2, out_ready=1 unless noted):
- LSL 0x0000_0003 by 31, carry_in=0 -> out 0x8000_0000, carry_out=1 (bit1), out_valid exactly 2 cycles after accept.
- ASR 0x8000_0018 by 4 -> 0xF800_0001, carry_out=1. LSR of the same input and shamt -> 0x0800_0001, carry_out=1.
- ROR 0x0000_00F8 by 4 -> 0x8000_000F, carry_out=1. ROR by 0 with carry_in=0 -> 0x0000_00F8, carry_out=0.
- Back-to-back: 8 ops on consecutive cycles -> 8 results on 8 consecutive cycles, in order, values matching a reference model; in_ready stays 1 throughout.
- Backpressure: out_ready=0, drive 3 ops.
  - First 2 accepted; in_ready=0 on the 3rd.
  - out_data stable while held.
  - Raise out_ready -> in_ready=1 that same cycle; all 3 emitted in order.
- Reset mid-flight: 2 ops in pipe, pulse rst_n low for a partial cycle.
  - out_valid=0 immediately (asynchronous); out_data=0, carry_out=0.
  - No stale result after release.
  - Next op returns after 2 cycles.
